// File: rtl/usr_xfer_ctrl_pkg.sv
// Shared encodings for the serial transfer controller and its universal shift register.
package usr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } usr_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_RESP  = 2'b10
    } xfer_state_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/usr_xfer_ctrl_if.sv
// Command, serial-link and response signals of the transfer controller.
interface usr_xfer_ctrl_if #(
    parameter int W  = 4,
    parameter int LW = $clog2(W + 1)
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_data;
    logic          cmd_dir;
    logic [LW-1:0] cmd_len;
    logic          ser_en;
    logic          ser_in;
    logic          ser_out;
    logic          ser_strobe;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          busy;

    modport master (
        output cmd_valid, cmd_data, cmd_dir, cmd_len, ser_en, ser_in, rsp_ready,
        input  cmd_ready, ser_out, ser_strobe, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_dir, cmd_len, ser_en, ser_in, rsp_ready,
        output cmd_ready, ser_out, ser_strobe, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/usr_core.sv
// W-bit universal shift register: hold, shift right, shift left or parallel load.
module usr_core
    import usr_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   mode,
    input  logic [W-1:0] D,
    input  logic         right_in,
    input  logic         left_in,
    output logic [W-1:0] Q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next register contents selected by the mode code.
    always_comb begin
        q_d = q_q;
        case (usr_mode_e'(mode))
            MODE_HOLD: q_d = q_q;
            MODE_SHR:  q_d = {right_in, q_q[W-1:1]};
            MODE_SHL:  q_d = {q_q[W-2:0], left_in};
            MODE_LOAD: q_d = D;
            default:   q_d = q_q;
        endcase
    end

    // Register storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= {W{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/usr_xfer_ctrl.sv
// Full-duplex serial transfer controller: load a word, exchange len bits, return the result.
module usr_xfer_ctrl
    import usr_pkg::*;
#(
    parameter int W  = 4,
    parameter int LW = $clog2(W + 1)
) (
    input  logic            clk,
    input  logic            reset,
    usr_xfer_ctrl_if.slave  io
);

    xfer_state_e   state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    usr_mode_e     mode_s;
    logic [W-1:0]  q_s;
    logic [LW-1:0] eff_len_s;

    // Zero and oversize lengths both mean a full-width exchange.
    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
        if ((len == {LW{1'b0}}) || (len > LW'(W))) begin
            return LW'(W);
        end else begin
            return len;
        end
    endfunction

    assign eff_len_s = clamp_len(io.cmd_len);

    // Next-state, counter and register-mode decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        mode_s  = MODE_HOLD;
        case (state_q)
            ST_IDLE: begin
                if (io.cmd_valid) begin
                    mode_s  = MODE_LOAD;
                    dir_d   = io.cmd_dir;
                    cnt_d   = eff_len_s;
                    state_d = ST_SHIFT;
                end else begin
                    mode_s  = MODE_HOLD;
                end
            end
            ST_SHIFT: begin
                if (io.ser_en) begin
                    mode_s = (dir_q == DIR_LEFT) ? MODE_SHL : MODE_SHR;
                    cnt_d  = cnt_q - LW'(1);
                    if (cnt_q == LW'(1)) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    mode_s = MODE_HOLD;
                end
            end
            ST_RESP: begin
                if (io.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state, remaining-bit counter and latched direction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {LW{1'b0}};
            dir_q   <= DIR_RIGHT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    usr_core #(.W(W)) u_core (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode_s),
        .D        (io.cmd_data),
        .right_in (io.ser_in),
        .left_in  (io.ser_in),
        .Q        (q_s)
    );

    // Outputs decode from state and Q only; the strobe alone also follows ser_en.
    always_comb begin
        io.cmd_ready  = (state_q == ST_IDLE);
        io.busy       = (state_q != ST_IDLE);
        io.rsp_valid  = (state_q == ST_RESP);
        io.ser_strobe = (state_q == ST_SHIFT) && io.ser_en;
        if (state_q == ST_SHIFT) begin
            io.ser_out = (dir_q == DIR_LEFT) ? q_s[W-1] : q_s[0];
        end else begin
            io.ser_out = 1'b0;
        end
        if (state_q == ST_RESP) begin
            io.rsp_data = q_s;
        end else begin
            io.rsp_data = {W{1'b0}};
        end
    end

endmodule

// File: tb/tb_usr_xfer_ctrl.sv
// Directed and randomized transfers checked against an arithmetic model of the exchange.
module tb_usr_xfer_ctrl;
    import usr_pkg::*;

    localparam int W  = 4;
    localparam int LW = $clog2(W + 1);

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    usr_xfer_ctrl_if #(.W(W), .LW(LW)) io ();

    usr_xfer_ctrl #(.W(W), .LW(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_cmd_ready"}, io.cmd_ready, 1);
        chk({tag, "_busy"}, io.busy, 0);
        chk({tag, "_ser_out"}, io.ser_out, 0);
        chk({tag, "_strobe"}, io.ser_strobe, 0);
        chk({tag, "_rsp_valid"}, io.rsp_valid, 0);
        chk({tag, "_rsp_data"}, io.rsp_data, 0);
    endtask

    // One full transfer, called at a negedge; rx[k] is the k-th bit placed on ser_in.
    task automatic xfer(input logic [W-1:0] data, input logic dir, input int lenf,
                        input logic [W-1:0] rx, input int stall_after, input int stall_n,
                        input int rsp_wait, input logic hold_next, input logic [W-1:0] next_data);
        int           len;
        int           k;
        int           st;
        int           r;
        int           fin;
        int           mask;
        logic         en;
        logic [W-1:0] exp_out;
        len     = (lenf == 0 || lenf > W) ? W : lenf;
        mask    = (1 << W) - 1;
        r       = 0;
        exp_out = '0;
        for (int i = 0; i < len; i++) begin
            exp_out[i] = dir ? data[W-1-i] : data[i];
            if (dir) r = (r << 1) | int'(rx[i]);
            else     r = r | (int'(rx[i]) << i);
        end
        if (dir) fin = ((int'(data) << len) & mask) | r;
        else     fin = (int'(data) >> len) | (r << (W - len));

        io.cmd_valid = 1'b1;
        io.cmd_data  = data;
        io.cmd_dir   = dir;
        io.cmd_len   = LW'(lenf);
        io.ser_en    = 1'b0;
        io.rsp_ready = 1'b0;
        #1;
        chk("accept_cmd_ready", io.cmd_ready, 1);
        chk("accept_busy", io.busy, 0);
        @(posedge clk);
        k  = 0;
        st = 0;
        while (k < len) begin
            @(negedge clk);
            io.cmd_valid = 1'b0;
            if (k == stall_after && st < stall_n) begin
                en = 1'b0;
                st++;
            end else begin
                en = 1'b1;
            end
            io.ser_en = en;
            io.ser_in = rx[k];
            #1;
            chk("shift_busy", io.busy, 1);
            chk("shift_cmd_ready", io.cmd_ready, 0);
            chk("shift_rsp_valid", io.rsp_valid, 0);
            chk("shift_strobe", io.ser_strobe, en);
            chk("shift_ser_out", io.ser_out, exp_out[k]);
            @(posedge clk);
            if (en) k++;
        end
        for (int w = 0; w <= rsp_wait; w++) begin
            @(negedge clk);
            io.rsp_ready = (w == rsp_wait);
            io.cmd_valid = hold_next;
            io.cmd_data  = next_data;
            io.ser_en    = 1'b1;
            #1;
            chk("rsp_valid", io.rsp_valid, 1);
            chk("rsp_data", io.rsp_data, fin);
            chk("rsp_cmd_ready", io.cmd_ready, 0);
            chk("rsp_strobe", io.ser_strobe, 0);
            chk("rsp_ser_out", io.ser_out, 0);
        end
        @(negedge clk);
        io.rsp_ready = 1'b0;
        io.cmd_valid = 1'b0;
        io.ser_en    = 1'b0;
        #1;
        chk_idle("after_rsp");
    endtask

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] nd;
        reset        = 1'b1;
        io.cmd_valid = 1'b0;
        io.cmd_data  = '0;
        io.cmd_dir   = 1'b0;
        io.cmd_len   = '0;
        io.ser_en    = 1'b0;
        io.ser_in    = 1'b0;
        io.rsp_ready = 1'b0;
        #1;
        chk_idle("reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // test-plan scenarios
        xfer(4'b1101, 1'b0, 4, 4'b1101, 99, 0, 0, 1'b0, 4'b0000);
        xfer(4'b1101, 1'b1, 0, 4'b0000, 99, 0, 0, 1'b0, 4'b0000);
        xfer(4'b1101, 1'b0, 2, 4'b0011, 99, 0, 0, 1'b0, 4'b0000);
        xfer(4'b1101, 1'b0, 4, 4'b1101, 2, 3, 0, 1'b0, 4'b0000);
        xfer(4'b0110, 1'b1, 3, 4'b0101, 99, 0, 5, 1'b1, 4'b1001);
        xfer(4'b1001, 1'b0, 7, 4'b1010, 99, 0, 0, 1'b0, 4'b0000);
        xfer(4'b0111, 1'b1, 1, 4'b0001, 99, 0, 1, 1'b0, 4'b0000);

        // reset mid-transfer after the second shift edge
        io.cmd_valid = 1'b1;
        io.cmd_data  = 4'b1011;
        io.cmd_dir   = 1'b0;
        io.cmd_len   = LW'(4);
        @(posedge clk);
        @(negedge clk);
        io.cmd_valid = 1'b0;
        io.ser_en    = 1'b1;
        io.ser_in    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_idle("async_reset");
        @(negedge clk);
        #1;
        chk_idle("held_reset");
        reset = 1'b0;
        xfer(4'b0101, 1'b1, 4, 4'b1100, 99, 0, 0, 1'b0, 4'b0000);

        // randomized transfers
        for (int n = 0; n < 30; n++) begin
            d  = W'($urandom);
            nd = W'($urandom);
            xfer(d, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), nd,
                 int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), W'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usr_xfer_ctrl.md
# usr_xfer_ctrl

Full-duplex serial transfer controller built around a W-bit universal shift register. It accepts a parallel word with a command handshake and loads it into the register. It then sequences a programmable number of shift cycles, sending one bit out and capturing one bit in on each enabled cycle, and returns the captured word through a response handshake. It sits between a parallel bus-side requester and a bit-serial link, and is the only agent that drives the shift register's mode select.

## Interface
- W, 4, register width; W >= 2
- LW, $clog2(W+1), width of the length field
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command; high only in IDLE
- cmd_data  in  W  word to transmit
- cmd_dir  in  1  0 = right shift (LSB first out, new bit enters MSB); 1 = left shift (MSB first out, new bit enters LSB)
- cmd_len  in  LW  number of bits to exchange, 1..W; 0 is treated as W; values above W are clamped to W
- ser_en  in  1  link enable; a shift occurs only when high
- ser_in  in  1  serial receive bit, sampled on each shift edge
- ser_out  out  1  serial transmit bit
- ser_strobe  out  1  high in a cycle whose rising edge performs a shift
- rsp_valid  out  1  received word available
- rsp_ready  in  1  requester accepts the response
- rsp_data  out  W  raw register contents at completion
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, SHIFT, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, the register mode is LOAD with D = cmd_data.
  - dir and the effective length are latched, the bit counter is set to the length, and the FSM goes to SHIFT.
  - Otherwise the register mode is HOLD.
- SHIFT, ser_en = 1:
  - The register mode is SHR (dir = 0) or SHL (dir = 1).
  - The serial input to the register is ser_in; the counter decrements.
  - When the counter reaches 1 on a shift edge, the FSM goes to RESP.
- SHIFT, ser_en = 0: the register mode is HOLD and the counter holds.
- SHR: Q <= {ser_in, Q[W-1:1]}; ser_out = Q[0].
- SHL: Q <= {Q[W-2:0], ser_in}; ser_out = Q[W-1].
- ser_out is driven from the current Q during SHIFT and is 0 in all other states.
- ser_strobe = (state == SHIFT) && ser_en.
- RESP:
  - rsp_valid = 1, rsp_data = Q, register mode HOLD.
  - rsp_valid and rsp_data stay stable until rsp_valid && rsp_ready, then the FSM goes to IDLE.
  - cmd_ready = 0 throughout RESP.
- Partial lengths (len < W) are not realigned. For SHR, the received bits occupy Q[W-1:W-len]; for SHL, they occupy Q[len-1:0].
- Reset, at any time including mid-transfer:
  - State goes to IDLE, Q = 0, and the counter and latched dir/len are cleared.
  - Output values during reset: cmd_ready = 1, busy = 0, ser_out = 0, ser_strobe = 0, rsp_valid = 0, rsp_data = 0.
  - Any transfer in progress is discarded and no response is produced.

## Timing
- Command accept edge E0 performs the load.
- With ser_en held high, the shift edges are E1..Elen, and rsp_valid is high in the cycle after Elen. Latency from command accept to response is len+1 cycles.
- Each ser_en = 0 cycle in SHIFT adds exactly one cycle.
- A response handshake at edge Er puts the FSM in IDLE after Er. The next command can be accepted at Er+1. Back-to-back throughput is one word per len+2 cycles.
- All outputs are functions of registered state and Q only (Moore), except ser_strobe, which also depends on ser_en. No input reaches cmd_ready or rsp_valid combinationally.

## Structure
- Package usr_pkg holds:
  - the mode encoding: HOLD = 2'b00, SHR = 2'b01, SHL = 2'b10, LOAD = 2'b11;
  - the FSM state enum;
  - the direction constants.
- Sub-module usr_core is a W-bit universal shift register. Ports: clk, reset, mode[1:0], D[W-1:0], right_in, left_in, Q[W-1:0]. SHR takes its serial input from right_in and SHL from left_in. The controller ties both to ser_in.
- The top level contains the FSM, the counter, the latched dir/len, and the output decode.

## Test plan
- W=4, cmd_data=1101, dir=0, len=4, ser_en=1, ser_in=1,0,1,1 -> ser_out=1,0,1,1 with ser_strobe high for 4 cycles; rsp_valid at accept+5; rsp_data=1101.
- data=1101, dir=1, len=0 (meaning 4), ser_in=0 -> ser_out=1,1,0,1; rsp_data=0000.
- data=1101, dir=0, len=2, ser_in=1,1 -> ser_out=1,0; rsp_data=1111; rsp_valid at accept+3.
- As the first scenario, with ser_en low for 3 cycles after the second shift -> Q and ser_out frozen and ser_strobe=0 during the stall; rsp_valid at accept+8; same rsp_data.
- rsp_ready held low for 5 cycles, with cmd_valid held high and new data -> rsp_valid and rsp_data stable, cmd_ready=0; the next command is accepted in the cycle after the response handshake.
- reset pulsed after the second shift edge -> asynchronous return to the reset values, no rsp_valid; a new command is accepted on the first edge after reset deasserts.
